// File: rtl/option_pkg.sv
// Option<T> encoding shared by option-carrying blocks.
// The tag sits in the MSB: 0 = Some, 1 = None. An Option<T> is $bits(T)+1 bits wide.
package option_pkg;

  localparam logic TAG_SOME = 1'b0;
  localparam logic TAG_NONE = 1'b1;

  // Widest Option this helper can build.
  localparam int unsigned OPT_MAX_W = 64;
  localparam int unsigned OPT_IDX_W = $clog2(OPT_MAX_W);

  // Width of Option<T> for a payload of payload_w bits.
  function automatic int unsigned option_width(input int unsigned payload_w);
    return payload_w + 1;
  endfunction

  // None with an all-zero payload; callers truncate to option_width(payload_w).
  function automatic logic [OPT_MAX_W-1:0] option_none(input int unsigned payload_w);
    logic [OPT_MAX_W-1:0] r;
    r = '0;
    r[OPT_IDX_W'(payload_w)] = TAG_NONE;
    return r;
  endfunction

endpackage

// File: rtl/option_rr_arbiter_if.sv
// Bus between N Option producers, the arbiter, and one sink.
//   req_i    : packed Option<int<W>> per requester, slot k at [k*(W+1) +: W+1]
//   ack_o    : one-hot combinational grant back to the requesters
//   ready_i  : sink accepts output__ this edge
//   output__ : registered Option<(uint<IDW>, int<W>)>
interface option_rr_arbiter_if #(
  parameter int unsigned N   = 4,
  parameter int unsigned W   = 16,
  parameter int unsigned IDW = (N > 1) ? $clog2(N) : 1
);
  logic [N*(W+1)-1:0] req_i;
  logic [N-1:0]       ack_o;
  logic               ready_i;
  logic [IDW+W:0]     output__;

  // Environment side: producers and sink.
  modport master (output req_i, output ready_i, input ack_o, input output__);
  // Arbiter side.
  modport slave  (input req_i, input ready_i, output ack_o, output output__);
endinterface

// File: rtl/option_rr_arbiter_pick.sv
// Combinational round-robin picker: first valid bit at or after ptr_i, wrapping.
//   valid_i  : request vector
//   ptr_i    : index with highest priority
//   found_o  : any valid bit set
//   idx_o    : chosen index
//   onehot_o : chosen index as one-hot (all zero when nothing found)
module rr_priority_pick #(
  parameter int unsigned N   = 4,
  parameter int unsigned IDW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]   valid_i,
  input  logic [IDW-1:0] ptr_i,
  output logic           found_o,
  output logic [IDW-1:0] idx_o,
  output logic [N-1:0]   onehot_o
);

  localparam int unsigned N2 = 2 * N;

  logic [N2-1:0] dbl_c;
  logic [N2-1:0] mask_c;
  logic [N2-1:0] masked_c;
  int unsigned   pos_c;

  // Lower copy masked below ptr, upper copy intact: the lowest set bit of the
  // doubled vector is the first requester in rotated order.
  always_comb begin
    dbl_c  = {valid_i, valid_i};
    mask_c = '0;
    for (int j = 0; j < int'(N2); j++) begin
      mask_c[j] = (32'(j) >= 32'(ptr_i));
    end
    masked_c = dbl_c & mask_c;

    pos_c = 0;
    for (int j = int'(N2) - 1; j >= 0; j--) begin
      if (masked_c[j]) pos_c = 32'(j);
    end

    found_o = |masked_c;
    idx_o   = (pos_c >= N) ? IDW'(pos_c - N) : IDW'(pos_c);

    onehot_o = '0;
    for (int k = 0; k < int'(N); k++) begin
      onehot_o[k] = found_o && (idx_o == IDW'(k));
    end
  end

endmodule

// File: rtl/option_rr_arbiter.sv
// Round-robin arbiter: N Option<int<W>> producers share one sink through a
// 1-entry registered output stage holding Option<(id, value)>.
//   clk_i : clock, rising edge
//   rst_i : synchronous active-high reset
//   bus   : req_i / ack_o / ready_i / output__ (see option_rr_arbiter_if)
module option_rr_arbiter
  import option_pkg::*;
#(
  parameter int unsigned N = 4,
  parameter int unsigned W = 16
) (
  input logic                clk_i,
  input logic                rst_i,
  option_rr_arbiter_if.slave bus
);

  localparam int unsigned IDW   = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned SLOTW = option_width(W);
  localparam int unsigned OUTW  = option_width(IDW + W);
  localparam logic [OUTW-1:0] OUT_NONE = OUTW'(option_none(OUTW - 1));

  logic [N-1:0]   valid_c;
  logic [W-1:0]   value_c [N];
  logic [W-1:0]   sel_value_c;
  logic           found_c;
  logic [IDW-1:0] idx_c;
  logic [N-1:0]   onehot_c;
  logic           load_c;
  logic           grant_c;

  logic [OUTW-1:0] out_d, out_q;
  logic [IDW-1:0]  ptr_d, ptr_q;

  // Unpack each slot; a request is Some when its tag bit is clear.
  for (genvar k = 0; k < int'(N); k++) begin : g_unpack
    assign valid_c[k] = (bus.req_i[k*SLOTW + W] == TAG_SOME);
    assign value_c[k] = bus.req_i[k*SLOTW +: W];
  end

  rr_priority_pick #(
    .N   (N),
    .IDW (IDW)
  ) u_pick (
    .valid_i  (valid_c),
    .ptr_i    (ptr_q),
    .found_o  (found_c),
    .idx_o    (idx_c),
    .onehot_o (onehot_c)
  );

  // Payload mux for the chosen slot.
  always_comb begin
    sel_value_c = '0;
    for (int k = 0; k < int'(N); k++) begin
      if (idx_c == IDW'(k)) sel_value_c = value_c[k];
    end
  end

  // Output slot can take a new value when empty or being drained this edge.
  assign load_c  = (out_q[OUTW-1] == TAG_NONE) || bus.ready_i;
  assign grant_c = load_c && found_c && !rst_i;

  assign bus.ack_o    = grant_c ? onehot_c : '0;
  assign bus.output__ = out_q;

  // Next output and pointer.
  always_comb begin
    out_d = out_q;
    ptr_d = ptr_q;
    if (load_c) begin
      if (found_c) begin
        out_d = {TAG_SOME, idx_c, sel_value_c};
        ptr_d = (idx_c == IDW'(N - 1)) ? '0 : IDW'(idx_c + 1'b1);
      end else begin
        out_d = OUT_NONE;
      end
    end
  end

  // Output stage and round-robin pointer.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_q <= OUT_NONE;
      ptr_q <= '0;
    end else begin
      out_q <= out_d;
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: tb/tb_option_rr_arbiter.sv
// Scoreboard bench for option_rr_arbiter (N=4, W=16).
module tb_option_rr_arbiter;

  localparam int unsigned N     = 4;
  localparam int unsigned W     = 16;
  localparam int unsigned IDW   = 2;
  localparam int unsigned SLOTW = W + 1;
  localparam int unsigned OUTW  = IDW + W + 1;
  localparam logic [OUTW-1:0] NONE_V = {1'b1, 18'd0};

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  option_rr_arbiter_if #(.N(N), .W(W)) bus ();

  option_rr_arbiter #(.N(N), .W(W)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [OUTW-1:0] exp_q [$];

  function automatic logic [OUTW-1:0] mk(input int id, input int v);
    return {1'b0, IDW'(id), W'(v)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_slot(input int k, input bit some, input int v);
    bus.req_i[k*SLOTW +: SLOTW] = {~some, W'(v)};
  endtask

  task automatic all_none();
    for (int k = 0; k < int'(N); k++) set_slot(k, 1'b0, 0);
  endtask

  // Check the grant this cycle and queue the output it must produce.
  task automatic expect_grant(input int id, input int v);
    #1;
    chk("grant_ack", 32'(bus.ack_o), 32'(1) << id);
    exp_q.push_back(mk(id, v));
  endtask

  // Monitor: every Some consumed by the sink is compared against the queue.
  always @(negedge clk) begin
    if (rst === 1'b0 && bus.output__[OUTW-1] === 1'b0 && bus.ready_i === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output actual=%h required=none t=%0t", bus.output__, $time);
      end else begin
        logic [OUTW-1:0] e;
        e = exp_q.pop_front();
        if (bus.output__ !== e) begin
          errors++;
          $display("FAIL output actual=%h required=%h t=%0t", bus.output__, e, $time);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    // 1: reset held with every slot Some
    rst = 1'b1;
    bus.ready_i = 1'b1;
    for (int k = 0; k < int'(N); k++) set_slot(k, 1'b1, k + 1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("reset_out", 32'(bus.output__), 32'(NONE_V));
      chk("reset_ack", 32'(bus.ack_o), 0);
    end
    all_none();
    rst = 1'b0;
    step();
    chk("idle_out", 32'(bus.output__), 32'(NONE_V));

    // 2: single requester
    set_slot(2, 1'b1, 123);
    expect_grant(2, 123);
    step();
    set_slot(2, 1'b0, 0);
    #1 chk("single_noack", 32'(bus.ack_o), 0);
    step();
    chk("single_empty", 32'(bus.output__), 32'(NONE_V));

    // 3: round robin from slot 0
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int k = 0; k < int'(N); k++) set_slot(k, 1'b1, k * 10);
    for (int i = 0; i < 6; i++) begin
      expect_grant(i % 4, (i % 4) * 10);
      step();
    end
    all_none();
    step();
    step();

    // 4: backpressure, pointer at 2
    bus.ready_i = 1'b0;
    set_slot(1, 1'b1, 7);
    expect_grant(1, 7);
    step();
    set_slot(1, 1'b0, 0);
    set_slot(3, 1'b1, 9);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_ack", 32'(bus.ack_o), 0);
      chk("bp_hold", 32'(bus.output__), 32'(mk(1, 7)));
      step();
    end
    bus.ready_i = 1'b1;
    expect_grant(3, 9);
    step();
    set_slot(3, 1'b0, 0);
    step();
    step();

    // 5: wrap, pointer 3 after granting slot 2
    set_slot(2, 1'b1, 5);
    expect_grant(2, 5);
    step();
    set_slot(2, 1'b0, 0);
    set_slot(0, 1'b1, 100);
    set_slot(3, 1'b1, 300);
    expect_grant(3, 300);
    step();
    set_slot(3, 1'b0, 0);
    expect_grant(0, 100);
    step();
    set_slot(0, 1'b0, 0);
    step();
    step();

    // 6: reset while output full and slot 1 pending
    bus.ready_i = 1'b0;
    set_slot(0, 1'b1, 11);
    #1 chk("mid_load_ack", 32'(bus.ack_o), 32'h1);
    step();
    set_slot(0, 1'b0, 0);
    set_slot(1, 1'b1, 22);
    #1;
    chk("mid_held_ack", 32'(bus.ack_o), 0);
    chk("mid_held_out", 32'(bus.output__), 32'(mk(0, 11)));
    rst = 1'b1;
    #1 chk("mid_rst_ack", 32'(bus.ack_o), 0);
    step();
    chk("mid_rst_out", 32'(bus.output__), 32'(NONE_V));
    rst = 1'b0;
    bus.ready_i = 1'b1;
    expect_grant(1, 22);
    step();
    set_slot(1, 1'b0, 0);
    step();
    step();

    chk("queue_drained", 32'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
